// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family (pipeline, bypass and conflict-free
// variants).
//   - ptr_width_f / count_width_f : sizing helpers for pointer and occupancy widths
//   - RESET_DATA_BIT              : fill bit used for storage and data at reset
//   - fifo_order_e                : per-cycle ordering of deq / enq / clear
package fifo_pkg;

    // The fill bit is replicated to WIDTH by each user.
    localparam logic RESET_DATA_BIT = 1'b0;

    // Rank of each operation within one cycle. A higher rank observes the
    // state left by the lower ranks and overrides them. The pipeline FIFO
    // uses deq < enq < clear. The bypass variant swaps deq and enq.
    typedef enum logic [1:0] {
        ORDER_DEQ   = 2'd0,
        ORDER_ENQ   = 2'd1,
        ORDER_CLEAR = 2'd2
    } fifo_order_e;

    // Returns ceil(log2(value)). Returns 0 for value <= 1.
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Pointer width is at least one bit, so that DEPTH=1 still has a legal vector.
    function automatic int ptr_width_f(input int depth);
        return (clog2_f(depth) < 1) ? 1 : clog2_f(depth);
    endfunction

    // Occupancy must represent 0..depth inclusive.
    function automatic int count_width_f(input int depth);
        return clog2_f(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around pointer with modulus DEPTH. DEPTH does not need to be a power of two.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : advance by one and wrap from DEPTH-1 to 0
//   clear      : synchronous return to 0. Overrides inc.
//   ptr        : registered pointer value
module fifo_ptr #(
    parameter int DEPTH = 2,
    parameter int PW    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          clear,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_r;

    // Pointer register: clear wins over increment. Wrap is explicit, so the
    // modulus is not limited to a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r <= '0;
        end else if (clear) begin
            ptr_r <= '0;
        end else if (inc) begin
            if (ptr_r == PW'(DEPTH - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= ptr_r + PW'(1);
            end
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/pipeline_fifo.sv
// N-entry pipeline FIFO. The per-cycle ordering is deq < enq < clear. A full
// FIFO still accepts a word in the same cycle that its head is dequeued, so
// throughput stays at one word per cycle at 100% occupancy.
//   clk, rst_n           : clock, asynchronous active-low reset
//   enq_valid/enq_data   : producer side. enq_ready = !full || deq_fire.
//   deq_valid/deq_data   : consumer side. Both come from registered state only.
//   deq_ready            : consumer takes the head this cycle
//   clear                : synchronous flush at the next edge. Overrides enq and deq.
//   count                : registered occupancy, 0..DEPTH
// Timing note: there is a combinational path from deq_ready to enq_ready (the
// full-flag bypass). There is no path from enq_valid to enq_ready.
module pipeline_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PW = ptr_width_f(DEPTH),
    localparam int CW = count_width_f(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enq_valid,
    input  logic [WIDTH-1:0] enq_data,
    output logic             enq_ready,
    output logic             deq_valid,
    output logic [WIDTH-1:0] deq_data,
    input  logic             deq_ready,
    input  logic             clear,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    head_ptr_s;
    logic [PW-1:0]    tail_ptr_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_next_s;
    logic             full_s;
    logic             empty_s;
    logic             deq_fire_s;
    logic             enq_fire_s;

    // Full and empty come from the occupancy count. Pointer equality cannot
    // tell full from empty.
    assign full_s     = (count_r == CW'(DEPTH));
    assign empty_s    = (count_r == '0);
    assign deq_valid  = !empty_s;
    assign deq_data   = mem_r[head_ptr_s];
    assign deq_fire_s = deq_valid && deq_ready;
    // Enqueue sees the state after the dequeue: a dequeue frees a slot in
    // the same cycle.
    assign enq_ready  = !full_s || deq_fire_s;
    assign enq_fire_s = enq_valid && enq_ready;
    assign count      = count_r;

    // Next occupancy. The result cannot leave 0..DEPTH, because enq is
    // blocked when full and deq is blocked when empty.
    always_comb begin
        count_next_s = count_r;
        if (clear) begin
            count_next_s = '0;
        end else begin
            count_next_s = count_r + CW'(enq_fire_s) - CW'(deq_fire_s);
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            count_r <= count_next_s;
        end
    end

    // Storage write. Clear does not zero the entries. A word offered in the
    // clear cycle is dropped, and the producer handles any retry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{RESET_DATA_BIT}};
            end
        end else if (enq_fire_s && !clear) begin
            mem_r[tail_ptr_s] <= enq_data;
        end
    end

    fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_head_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (deq_fire_s),
        .clear (clear),
        .ptr   (head_ptr_s)
    );

    fifo_ptr #(.DEPTH(DEPTH), .PW(PW)) u_tail_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (enq_fire_s),
        .clear (clear),
        .ptr   (tail_ptr_s)
    );

endmodule

// File: tb/tb_pipeline_fifo.sv
// Directed bench for pipeline_fifo. One instance uses DEPTH=2 and WIDTH=8.
// A second instance uses DEPTH=3 and WIDTH=8 and runs the wrap-around stream.
module tb_pipeline_fifo;

    logic       clk;
    logic       rst_n;

    logic       ev2, er2, dv2, dr2, clr2;
    logic [7:0] ed2, dq2;
    logic [1:0] cnt2;

    logic       ev3, er3, dv3, dr3, clr3;
    logic [7:0] ed3, dq3;
    logic [1:0] cnt3;

    int n_checks;
    int n_pass;

    pipeline_fifo #(.WIDTH(8), .DEPTH(2)) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq_valid (ev2),
        .enq_data  (ed2),
        .enq_ready (er2),
        .deq_valid (dv2),
        .deq_data  (dq2),
        .deq_ready (dr2),
        .clear     (clr2),
        .count     (cnt2)
    );

    pipeline_fifo #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .enq_valid (ev3),
        .enq_data  (ed3),
        .enq_ready (er3),
        .deq_valid (dv3),
        .deq_data  (dq3),
        .deq_ready (dr3),
        .clear     (clr3),
        .count     (cnt3)
    );

    always #5 clk = ~clk;

    // Protocol properties of the stream instance.
    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) cnt3 <= 2'd3);
    a_no_enq_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(ev3 && er3 && cnt3 == 2'd3 && !(dv3 && dr3)));
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (dv3 && !dr3) |=> $stable(dq3));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Enqueue one word into dut2 with the consumer stalled.
    task automatic enq2(input logic [7:0] d);
        @(negedge clk);
        ev2 = 1'b1; ed2 = d; dr2 = 1'b0;
        @(posedge clk);
    endtask

    logic [31:0] stall_pat;
    int sent;
    int rcvd;

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        ev2 = 1'b0; ed2 = 8'h00; dr2 = 1'b0; clr2 = 1'b0;
        ev3 = 1'b0; ed3 = 8'h00; dr3 = 1'b0; clr3 = 1'b0;
        n_checks = 0; n_pass = 0;
        stall_pat = 32'b1101_0110_1011_1110_1100_1010_1110_0000;

        // Reset, then idle for 5 cycles.
        @(negedge clk);
        check("rst_dv", dv2, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_dv", dv2, 1'b0);
            check("idle_er", er2, 1'b1);
            check("idle_cnt", cnt2, 2'd0);
            check("idle_dq", dq2, 8'h00);
        end

        // Fill with A1 and B2, then drain.
        enq2(8'hA1);
        enq2(8'hB2);
        @(negedge clk);
        ev2 = 1'b0;
        #1;
        check("fill_cnt", cnt2, 2'd2);
        check("fill_er", er2, 1'b0);
        check("fill_dq", dq2, 8'hA1);
        dr2 = 1'b1;
        #1;
        check("drain_er_bypass", er2, 1'b1);
        @(negedge clk);
        check("drain_dq2", dq2, 8'hB2);
        check("drain_cnt1", cnt2, 2'd1);
        @(negedge clk);
        dr2 = 1'b0;
        check("drain_cnt0", cnt2, 2'd0);
        check("drain_dv0", dv2, 1'b0);

        // Full-throughput case: enq and deq in the same cycle while full.
        enq2(8'h11);
        enq2(8'h22);
        @(negedge clk);
        ev2 = 1'b1; ed2 = 8'h33; dr2 = 1'b1;
        #1;
        check("bp_er", er2, 1'b1);
        check("bp_head", dq2, 8'h11);
        @(negedge clk);
        ev2 = 1'b0;
        #1;
        check("bp_cnt", cnt2, 2'd2);
        check("bp_dq22", dq2, 8'h22);
        @(negedge clk);
        check("bp_dq33", dq2, 8'h33);
        check("bp_cnt1", cnt2, 2'd1);
        @(negedge clk);
        dr2 = 1'b0;
        check("bp_cnt0", cnt2, 2'd0);

        // Clear while enq and deq both fire.
        enq2(8'h01);
        enq2(8'h02);
        @(negedge clk);
        clr2 = 1'b1; ev2 = 1'b1; ed2 = 8'h03; dr2 = 1'b1;
        @(negedge clk);
        clr2 = 1'b0; ev2 = 1'b0; dr2 = 1'b0;
        #1;
        check("clr_cnt", cnt2, 2'd0);
        check("clr_dv", dv2, 1'b0);
        // Empty FIFO with enq and deq offered: only the enq fires.
        ev2 = 1'b1; ed2 = 8'h5C; dr2 = 1'b1;
        #1;
        check("clr_empty_dv", dv2, 1'b0);
        @(negedge clk);
        ev2 = 1'b0; dr2 = 1'b0;
        #1;
        check("clr_next_dv", dv2, 1'b1);
        check("clr_next_dq", dq2, 8'h5C);
        check("clr_next_cnt", cnt2, 2'd1);

        // Asynchronous reset between edges while one word is held.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_dv", dv2, 1'b0);
        check("arst_cnt", cnt2, 2'd0);
        check("arst_dq", dq2, 8'h00);
        check("arst_er", er2, 1'b1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("arst_post_dv", dv2, 1'b0);
        ev2 = 1'b1; ed2 = 8'h77;
        @(negedge clk);
        ev2 = 1'b0; dr2 = 1'b1;
        #1;
        check("arst_post_dq", dq2, 8'h77);
        check("arst_post_cnt", cnt2, 2'd1);
        @(negedge clk);
        dr2 = 1'b0;
        check("arst_post_cnt0", cnt2, 2'd0);

        // DEPTH=3: stream words 0..9 through a fixed stall pattern.
        sent = 0;
        rcvd = 0;
        for (int cyc = 0; cyc < 80 && rcvd < 10; cyc++) begin
            @(negedge clk);
            ev3 = (sent < 10);
            ed3 = 8'(sent);
            dr3 = stall_pat[cyc % 32];
            #1;
            if (cyc == 4) begin
                check("wrap_full_cnt", cnt3, 2'd3);
            end
            if (dv3 && dr3) begin
                check("wrap_order", dq3, 32'(rcvd));
                rcvd++;
            end
            if (ev3 && er3) begin
                sent++;
            end
        end
        @(negedge clk);
        ev3 = 1'b0; dr3 = 1'b0;
        #1;
        check("wrap_rcvd", rcvd, 32'd10);
        check("wrap_sent", sent, 32'd10);
        check("wrap_cnt0", cnt3, 2'd0);
        check("wrap_dv0", dv3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
